// File: rtl/adc_pkg.sv
// adc_pkg: shared definitions for the EBI-mapped serial ADC controller.
//   Register offsets (addr[7:0]), ID constant, frame length and the
//   controller state encoding.
package adc_pkg;

  localparam logic [7:0]  REG_CMD    = 8'd0;   // W: command word, starts a frame
  localparam logic [7:0]  REG_SAMPLE = 8'd1;   // R: last sample, read clears valid
  localparam logic [7:0]  REG_STATUS = 8'd2;   // R: {13'b0, overrun, valid, busy}
  localparam logic [7:0]  REG_AUTO   = 8'd3;   // R/W: bit0 auto (continuous build only)
  localparam logic [7:0]  REG_ID     = 8'd9;   // R: constant ID

  localparam logic [15:0] ADC_ID     = 16'h0ADC;
  localparam int          FRAME_BITS = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    CONV  = 2'd3
  } adc_state_t;

endpackage

// File: rtl/adc_sclk_div.sv
// adc_sclk_div: serial clock generator for the ADC frame.
//   While i_en is high, counts CLK_DIV cycles per half-period and toggles
//   o_sclk. o_rise_tick / o_fall_tick are single-cycle pulses marking the
//   clock edge on which o_sclk will go high / low. Dropping i_en returns the
//   divider to count 0 with o_sclk low, so every enable starts a clean period.
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset
//   i_en             run the divider
//   o_rise_tick      o_sclk rises on this edge
//   o_fall_tick      o_sclk falls on this edge
//   o_sclk           serial clock level (idles low)
module adc_sclk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_rise_tick,
  output logic o_fall_tick,
  output logic o_sclk
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_sclk;
  logic          w_wrap;

  assign w_wrap = i_en && (r_cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (!i_en) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (w_wrap) begin
      r_cnt  <= '0;
      r_sclk <= ~r_sclk;
    end else begin
      r_cnt  <= r_cnt + CW'(1);
    end
  end

  assign o_rise_tick = w_wrap & ~r_sclk;
  assign o_fall_tick = w_wrap &  r_sclk;
  assign o_sclk      = r_sclk;

endmodule

// File: rtl/adc_control.sv
// adc_control: EBI-mapped controller for a 16-bit serial ADC.
//   A write to register 0 starts a frame: nCs drops, a 16-bit command is
//   shifted out on adc_din (changing on falling adc_sclk) while 16 bits are
//   captured from adc_dout on rising adc_sclk, MSB first. The sample is held
//   in a readable register with valid/overrun status.
//   Frame: SETUP (CLK_DIV) + SHIFT (32*CLK_DIV) + CONV (CONV_CYCLES) cycles.
// Build option: define ADC_CONTINUOUS_EN to enable register 3 (bit0 = auto),
//   which makes CONV loop back to SETUP for back-to-back frames.
// Ports:
//   ebi_clk, nReset        clock, async active-low reset
//   enable, re, wr         EBI controller enable and strobes
//   data[15:0], addr[18:0] EBI write data / address ([18:8] slot, [7:0] reg)
//   out_data[15:0]         registered read data, 0 when not reading
//   nCs, adc_sclk, adc_din ADC chip select, serial clock, command bit
//   adc_dout               ADC data bit
module adc_control
  import adc_pkg::*;
#(
  parameter int POSITION    = 0,
  parameter int CLK_DIV     = 4,
  parameter int CONV_CYCLES = 16
) (
  input  logic        ebi_clk,
  input  logic        nReset,
  input  logic        enable,
  input  logic        re,
  input  logic        wr,
  input  logic [15:0] data,
  input  logic [18:0] addr,
  output logic [15:0] out_data,
  output logic        nCs,
  output logic        adc_sclk,
  output logic        adc_din,
  input  logic        adc_dout
);

  localparam int CNT_MAX = (CLK_DIV > CONV_CYCLES) ? CLK_DIV : CONV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  adc_state_t   r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]   r_bit;
  logic [15:0]  r_cmd_word;
  logic [15:0]  r_shift;
  logic [15:0]  r_rx;
  logic [15:0]  r_sample;
  logic         r_valid;
  logic         r_overrun;

  logic         w_cs, w_rd, w_wr;
  logic [7:0]   w_reg;
  logic         w_start, w_setup_done, w_conv_done, w_last_fall;
  logic         w_rise, w_fall, w_sclk;
  logic         w_busy, w_auto;
  logic         w_rd_sample, w_rd_status, w_ovr_set;
  logic [15:0]  w_rdata;

  assign w_cs   = enable && (addr[18:8] == 11'(POSITION));
  assign w_rd   = w_cs & re;
  assign w_wr   = w_cs & wr;
  assign w_reg  = addr[7:0];
  assign w_busy = (r_state != IDLE);

  // Command writes only take effect from IDLE.
  assign w_start = w_wr && (w_reg == REG_CMD) && (r_state == IDLE);

`ifdef ADC_CONTINUOUS_EN
  logic r_auto;
  always_ff @(posedge ebi_clk or negedge nReset) begin
    if (!nReset)                          r_auto <= 1'b0;
    else if (w_wr && (w_reg == REG_AUTO)) r_auto <= data[0];
  end
  assign w_auto = r_auto;
`else
  assign w_auto = 1'b0;
`endif

  adc_sclk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .i_clk       (ebi_clk),
    .i_rst_n     (nReset),
    .i_en        (r_state == SHIFT),
    .o_rise_tick (w_rise),
    .o_fall_tick (w_fall),
    .o_sclk      (w_sclk)
  );

  assign w_setup_done = (r_state == SETUP) && (r_cnt == CNT_W'(CLK_DIV - 1));
  assign w_conv_done  = (r_state == CONV)  && (r_cnt == CNT_W'(CONV_CYCLES - 1));
  // All 16 rises have already loaded r_rx by the 16th fall.
  assign w_last_fall  = (r_state == SHIFT) && w_fall && (r_bit == 4'(FRAME_BITS - 1));

  // State register
  always_ff @(posedge ebi_clk or negedge nReset) begin
    if (!nReset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:  if (w_start)      w_state_nxt = SETUP;
      SETUP: if (w_setup_done) w_state_nxt = SHIFT;
      SHIFT: if (w_last_fall)  w_state_nxt = CONV;
      CONV:  if (w_conv_done)  w_state_nxt = w_auto ? SETUP : IDLE;
      default:                 w_state_nxt = IDLE;
    endcase
  end

  // Phase counter is cleared on every state change and only runs in the
  // timed states (SETUP, CONV); SHIFT timing lives in the divider.
  always_ff @(posedge ebi_clk or negedge nReset) begin
    if (!nReset) begin
      r_cnt <= '0;
      r_bit <= '0;
    end else begin
      if (w_state_nxt != r_state)                    r_cnt <= '0;
      else if (r_state == SETUP || r_state == CONV)  r_cnt <= r_cnt + CNT_W'(1);
      if (r_state != SHIFT) r_bit <= '0;
      else if (w_fall)      r_bit <= r_bit + 4'd1;
    end
  end

  // Command / receive shift registers. r_cmd_word keeps the written word so
  // continuous frames can reload it after the shifter has been emptied.
  always_ff @(posedge ebi_clk or negedge nReset) begin
    if (!nReset) begin
      r_cmd_word <= '0;
      r_shift    <= '0;
      r_rx       <= '0;
    end else begin
      if (w_start) begin
        r_cmd_word <= data;
        r_shift    <= data;
      end else if (r_state == CONV && w_state_nxt == SETUP) begin
        r_shift    <= r_cmd_word;
      end else if (r_state == SHIFT && w_fall) begin
        r_shift    <= {r_shift[14:0], 1'b0};
      end
      if (r_state == SHIFT && w_rise) r_rx <= {r_rx[14:0], adc_dout};
    end
  end

  // Sample and status. A sample read coinciding with a latch returns the
  // old sample and neither clears valid nor counts as an overrun; a set of
  // overrun beats a simultaneous status-read clear.
  assign w_rd_sample = w_rd && (w_reg == REG_SAMPLE);
  assign w_rd_status = w_rd && (w_reg == REG_STATUS);
  assign w_ovr_set   = w_last_fall && r_valid && !w_rd_sample;

  always_ff @(posedge ebi_clk or negedge nReset) begin
    if (!nReset) begin
      r_sample  <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_last_fall) r_sample <= r_rx;
      if (w_last_fall)      r_valid <= 1'b1;
      else if (w_rd_sample) r_valid <= 1'b0;
      if (w_ovr_set)        r_overrun <= 1'b1;
      else if (w_rd_status) r_overrun <= 1'b0;
    end
  end

  // Read mux
  always_comb begin
    w_rdata = '0;
    case (w_reg)
      REG_SAMPLE: w_rdata = r_sample;
      REG_STATUS: w_rdata = {13'b0, r_overrun, r_valid, w_busy};
`ifdef ADC_CONTINUOUS_EN
      REG_AUTO:   w_rdata = {15'b0, r_auto};
`endif
      REG_ID:     w_rdata = ADC_ID;
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge ebi_clk or negedge nReset) begin
    if (!nReset)   out_data <= '0;
    else if (w_rd) out_data <= w_rdata;
    else           out_data <= '0;
  end

  // Pins decode straight from reset-cleared state so an async reset
  // releases the ADC in the same cycle.
  assign nCs      = !(r_state == SETUP || r_state == SHIFT);
  assign adc_sclk = w_sclk;
  assign adc_din  = nCs ? 1'b0 : r_shift[15];

endmodule
